ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, etc.) from the Z88 side to the keyboard over the same ps2clk/ps2dat pair that the keyboard receiver listens on. It performs the inhibit/request-to-send sequence, shifts data on device-generated clock edges, and checks the device ACK. It drives the lines open-drain via output-enables; the pads are pulled low when `*_oe` = 1. It sits beside the PS/2 keyboard receiver, which must ignore the bus while `rx_inhibit` = 1.

## Interface
- `INHIBIT_CYCLES`, 2000: clk cycles ps2clk is held low before request (≥100 µs at 20 MHz).
- `REQ_CYCLES`, 16: clk cycles both lines are held low before clock release.
- `TIMEOUT_CYCLES`, 40000: maximum clk cycles without a ps2clk falling edge while waiting on the device.

- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2clk` in 1: PS/2 clock pin level (asynchronous).
- `ps2dat` in 1: PS/2 data pin level (asynchronous).
- `tx_data` in 8: byte to send; sampled on accept.
- `tx_valid` in 1: send request.
- `tx_ready` out 1: 1 in IDLE only; accept = `tx_valid & tx_ready`.
- `tx_done` out 1: one-cycle pulse, frame sent and ACKed.
- `tx_err` out 1: one-cycle pulse, no ACK or timeout.
- `ps2clk_oe` out 1: 1 = pull ps2clk low.
- `ps2dat_oe` out 1: 1 = pull ps2dat low.
- `rx_inhibit` out 1: 1 whenever state ≠ IDLE.

## Operation
- Input conditioning: 2-FF synchronizer on `ps2clk` and `ps2dat`, plus a third register on the clock. A falling edge is detected when the third register = 1 and the second = 0.
- On accept: latch `tx_data` into a shift register. Compute parity = ~^tx_data (odd parity). Set the edge counter to 0 and go to INHIBIT.
- INHIBIT: `ps2clk_oe`=1, `ps2dat_oe`=0 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: `ps2clk_oe`=1, `ps2dat_oe`=1 (start bit 0) for REQ_CYCLES cycles, then go to SHIFT.
- SHIFT: `ps2clk_oe`=0, and the watchdog is cleared on entry. On each detected falling edge the edge counter n is incremented. After edge n:
  - n = 1..8: present data bit n-1, LSB first.
  - n = 9: present parity.
  - n = 10: present stop (release data).
  - `ps2dat_oe` = NOT(presented bit).
- On edge 11: sample synchronized `ps2dat`. If 0, go to WAITIDLE. If 1, pulse `tx_err` and go to IDLE.
- WAITIDLE: wait until synchronized ps2clk = 1 and ps2dat = 1, then pulse `tx_done` and go to IDLE.
- Watchdog: counts in SHIFT and WAITIDLE and is cleared on every falling edge. At TIMEOUT_CYCLES it releases both lines, pulses `tx_err` and goes to IDLE.
- `tx_done` and `tx_err` are mutually exclusive, and each is a single cycle.
- `tx_valid` while not ready is ignored; the request is not queued.
- Falling edges seen in IDLE, INHIBIT or REQ are ignored.

## Timing
- Reset values: `ps2clk_oe`=0, `ps2dat_oe`=0, `tx_ready`=1, `tx_done`=0, `tx_err`=0, `rx_inhibit`=0, state IDLE, counters 0.
- Reset mid-frame: both lines are released asynchronously, in the same instant as `reset_n` falls.
- Accept at cycle T:
  - `ps2clk_oe` rises at T+1.
  - `ps2dat_oe` rises at T+1+INHIBIT_CYCLES.
  - `ps2clk_oe` falls at T+1+INHIBIT_CYCLES+REQ_CYCLES.
- `tx_ready` falls at T+1 and `rx_inhibit` rises at T+1.
- Bit update: `ps2dat_oe` changes at most 4 clk cycles after the pin's falling edge (2 sync + edge + register).
- `tx_done` / `tx_err` assert in the cycle the state machine leaves WAITIDLE/SHIFT. `tx_ready` returns to 1 the following cycle.
- Watchdog width: ceil(log2(TIMEOUT_CYCLES+1)) bits. Timer widths are sized from the parameters.

## Test plan
- Reset: hold `reset_n`=0 -> all outputs at reset values. Pulse `tx_valid` while in reset -> no change.
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - `ps2clk_oe` is low for exactly INHIBIT_CYCLES cycles before `ps2dat_oe`.
  - The device samples 0 | 1,0,1,1,0,1,1,1 | parity 1 | stop 1.
  - Exactly one `tx_done`, no `tx_err`.
- Send 0x01, then 0xFF back-to-back: parity bits 0 and 1 respectively. Between frames `tx_ready` is 1 for ≥1 cycle.
- Device leaves data high at edge 11 (no ACK), byte 0x00 -> `tx_err` one pulse, no `tx_done`, both oe = 0.
- Device stops clocking after edge 4 -> exactly TIMEOUT_CYCLES cycles after the last edge, `tx_err` pulses and the lines are released. `tx_valid` asserted mid-frame is ignored (only one frame is observed).
- Assert `reset_n`=0 during SHIFT (after edge 6) -> oe outputs drop immediately. After release, a new 0xF4 transfer completes with `tx_done`.

Source files
------------

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter.
// Performs the inhibit / request-to-send sequence, shifts one command byte
// out on device-generated clock edges and checks the device ACK. Both pins
// are driven open-drain through the *_oe outputs (1 = pull low).
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 2000,
   parameter int REQ_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 40000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2clk,
   input  logic       ps2dat,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       ps2clk_oe,
   output logic       ps2dat_oe,
   output logic       rx_inhibit
);

   // Phase timer covers INHIBIT and REQ; the watchdog is sized for the timeout.
   localparam int TMR_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMR_W-1:0] REQ_LAST = TMR_W'(REQ_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   // Edge 11 is the ACK edge; edges 1..10 present data, parity and stop.
   localparam logic [3:0]       ACK_EDGE_PREV = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      WAITIDLE
   } state_t;

   state_t           state_reg, state_next;
   logic [TMR_W-1:0] tmr_reg, tmr_next;
   logic [WD_W-1:0]  wd_reg, wd_next;
   logic [3:0]       edge_cnt_reg, edge_cnt_next;
   // {stop, parity, data[7:0]} -- indexed by the edge count before increment.
   logic [9:0]       frame_reg, frame_next;
   logic             bit_oe_reg, bit_oe_next;

   logic [2:0]       clk_sync_reg;
   logic [1:0]       dat_sync_reg;
   logic             clk_s;
   logic             dat_s;
   logic             clk_fall;

   assign clk_s    = clk_sync_reg[1];
   assign dat_s    = dat_sync_reg[1];
   assign clk_fall = clk_sync_reg[2] & ~clk_sync_reg[1];

   // Bring the asynchronous pin levels into the clk domain; the third clock
   // stage provides the previous value for falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_reg <= 3'b111;
         dat_sync_reg <= 2'b11;
      end else begin
         clk_sync_reg <= {clk_sync_reg[1:0], ps2clk};
         dat_sync_reg <= {dat_sync_reg[0], ps2dat};
      end
   end

   // State and datapath registers; reset releases both pins immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         tmr_reg      <= '0;
         wd_reg       <= '0;
         edge_cnt_reg <= '0;
         frame_reg    <= '0;
         bit_oe_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tmr_reg      <= tmr_next;
         wd_reg       <= wd_next;
         edge_cnt_reg <= edge_cnt_next;
         frame_reg    <= frame_next;
         bit_oe_reg   <= bit_oe_next;
      end
   end

   // Next-state logic plus the single-cycle done/error pulses.
   always_comb begin
      state_next    = state_reg;
      tmr_next      = tmr_reg;
      wd_next       = wd_reg;
      edge_cnt_next = edge_cnt_reg;
      frame_next    = frame_reg;
      bit_oe_next   = bit_oe_reg;
      tx_done       = 1'b0;
      tx_err        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (tx_valid) begin
               frame_next    = {1'b1, ~^tx_data, tx_data};
               edge_cnt_next = '0;
               tmr_next      = '0;
               state_next    = INHIBIT;
            end
         end

         INHIBIT: begin
            if (tmr_reg == INH_LAST) begin
               tmr_next   = '0;
               state_next = REQ;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end

         REQ: begin
            if (tmr_reg == REQ_LAST) begin
               // Start bit stays driven low until the first device edge.
               tmr_next      = '0;
               wd_next       = '0;
               edge_cnt_next = '0;
               bit_oe_next   = 1'b1;
               state_next    = SHIFT;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end

         SHIFT: begin
            if (clk_fall) begin
               wd_next       = '0;
               edge_cnt_next = edge_cnt_reg + 4'd1;
               if (edge_cnt_reg == ACK_EDGE_PREV) begin
                  bit_oe_next = 1'b0;
                  if (!dat_s) begin
                     state_next = WAITIDLE;
                  end else begin
                     tx_err     = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  bit_oe_next = ~frame_reg[edge_cnt_reg];
               end
            end else if (wd_reg == WD_LAST) begin
               bit_oe_next = 1'b0;
               tx_err      = 1'b1;
               state_next  = IDLE;
            end else begin
               wd_next = wd_reg + WD_W'(1);
            end
         end

         WAITIDLE: begin
            if (clk_s && dat_s) begin
               tx_done    = 1'b1;
               state_next = IDLE;
            end else if (clk_fall) begin
               wd_next = '0;
            end else if (wd_reg == WD_LAST) begin
               tx_err     = 1'b1;
               state_next = IDLE;
            end else begin
               wd_next = wd_reg + WD_W'(1);
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Pin drivers and handshake outputs decoded from the current state.
   always_comb begin
      tx_ready   = (state_reg == IDLE);
      rx_inhibit = (state_reg != IDLE);
      ps2clk_oe  = (state_reg == INHIBIT) || (state_reg == REQ);
      ps2dat_oe  = (state_reg == REQ) || ((state_reg == SHIFT) && bit_oe_reg);
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard testbench for ps2_tx with a behavioural PS/2 device model.
// Timing parameters are scaled down so the run stays short.
module tb_ps2_tx;

   localparam int INH = 50;
   localparam int REQ = 16;
   localparam int TMO = 600;
   localparam int H   = 20;   // device clock half period in clk cycles

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, ps2clk_oe, ps2dat_oe, rx_inhibit;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   wire        ps2clk = ~(ps2clk_oe | dev_clk_low);
   wire        ps2dat = ~(ps2dat_oe | dev_dat_low);

   always #5 clk = ~clk;

   ps2_tx #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES    (REQ),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2clk    (ps2clk),
      .ps2dat    (ps2dat),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_done   (tx_done),
      .tx_err    (tx_err),
      .ps2clk_oe (ps2clk_oe),
      .ps2dat_oe (ps2dat_oe),
      .rx_inhibit(rx_inhibit)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2 == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   // kind: 0 = expect tx_done, 1 = expect tx_err (no ACK), 2 = expect tx_err (timeout)
   typedef struct {
      logic [7:0] data;
      int         kind;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- device model ----------------
   int          dev_stop_after = 11;
   bit          dev_ack = 1'b1;
   logic [10:0] cap = '0;
   int          last_fall_cyc = 0;
   int          dev_frames = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && ps2clk_oe && ps2dat_oe) begin
            while (ps2clk_oe) @(negedge clk);
            cap = '0;
            repeat (H) @(negedge clk);
            cap[0] = ps2dat;
            for (int k = 1; k <= 11; k++) begin
               if (k > dev_stop_after) break;
               if (k == 11 && dev_ack) begin
                  dev_dat_low = 1'b1;
                  repeat (2) @(negedge clk);
               end
               dev_clk_low   = 1'b1;
               last_fall_cyc = cyc;
               repeat (H) @(negedge clk);
               dev_clk_low = 1'b0;
               repeat (5) @(negedge clk);
               if (k <= 10) cap[k] = ps2dat;
               repeat (H - 5) @(negedge clk);
               if (k == 11) dev_dat_low = 1'b0;
            end
            dev_frames++;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   int outcomes = 0;
   bit post_pending = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (post_pending) begin
            post_pending = 1'b0;
            check("ready_after_end", tx_ready, 1);
            check("oe_released_after_end", {ps2clk_oe, ps2dat_oe}, 0);
         end
         if (reset_n && (tx_done || tx_err)) begin
            check("done_err_exclusive", tx_done & tx_err, 0);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_pulse: done=%0b err=%0b, expected none", tx_done, tx_err);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("outcome_is_done", tx_done, (e.kind == 0));
               if (e.kind != 2) begin
                  check("frame_bits", cap, model_frame(e.data));
                  $display("frame %02h: captured %011b kind %0d", e.data, cap, e.kind);
               end else begin
                  int lat;
                  lat = cyc - last_fall_cyc;
                  checks++;
                  if (lat >= TMO && lat <= TMO + 4) passes++;
                  else $display("FAIL timeout_latency: got %0d, expected %0d..%0d", lat, TMO, TMO + 4);
                  $display("timeout frame %02h: err after %0d cycles", e.data, lat);
               end
            end
            outcomes++;
            post_pending = 1'b1;
         end
      end
   end

   // ---------------- phase-length monitor ----------------
   int  inh_len = 0;
   int  req_len = 0;
   int  starts = 0;
   logic prev_clk_oe = 1'b0;
   logic prev_inh = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            inh_len = 0;
            req_len = 0;
         end else begin
            if (ps2clk_oe && !ps2dat_oe) inh_len++;
            if (ps2clk_oe && ps2dat_oe) req_len++;
            if (prev_clk_oe && !ps2clk_oe) begin
               check("inhibit_length", inh_len, INH);
               check("request_length", req_len, REQ);
               inh_len = 0;
               req_len = 0;
            end
            if (!prev_inh && rx_inhibit) starts++;
         end
         prev_clk_oe = ps2clk_oe;
         prev_inh    = rx_inhibit;
      end
   end

   // ---------------- stimulus ----------------
   int frames_sent = 0;

   task automatic send(input logic [7:0] d, input int kind);
      int budget;
      budget = 0;
      @(negedge clk);
      while (!tx_ready && budget < 5000) begin
         @(negedge clk);
         budget++;
      end
      if (!tx_ready) fail_now("wait_ready");
      tx_data  = d;
      tx_valid = 1'b1;
      exp_q.push_back('{data: d, kind: kind});
      frames_sent++;
      @(negedge clk);
      tx_valid = 1'b0;
      check("accept_clk_oe", ps2clk_oe, 1);
      check("accept_dat_oe", ps2dat_oe, 0);
      check("accept_ready_low", tx_ready, 0);
      check("accept_rx_inhibit", rx_inhibit, 1);
   endtask

   task automatic wait_outcome(input int target);
      int budget;
      budget = 0;
      while (outcomes < target && budget < 20000) begin
         @(negedge clk);
         budget++;
      end
      if (outcomes < target) fail_now("wait_outcome");
   endtask

   task automatic wait_dev(input int target);
      int budget;
      budget = 0;
      while (dev_frames < target && budget < 20000) begin
         @(negedge clk);
         budget++;
      end
      if (dev_frames < target) fail_now("wait_device");
   endtask

   initial begin
      logic [7:0] d;
      int n;

      // Reset, with a send request that must be ignored.
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      tx_data  = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      check("reset_clk_oe", ps2clk_oe, 0);
      check("reset_dat_oe", ps2dat_oe, 0);
      check("reset_ready", tx_ready, 1);
      check("reset_done", tx_done, 0);
      check("reset_err", tx_err, 0);
      check("reset_rx_inhibit", rx_inhibit, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_idle", rx_inhibit, 0);

      // 0xED with ACK.
      n = outcomes;
      send(8'hED, 0);
      wait_outcome(n + 1);

      // 0x01 then 0xFF back-to-back.
      send(8'h01, 0);
      wait_outcome(n + 2);
      send(8'hFF, 0);
      wait_outcome(n + 3);

      // Random bytes.
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         send(d, 0);
         wait_outcome(n + 4 + i);
      end
      n = outcomes;

      // No ACK on byte 0x00.
      dev_ack = 1'b0;
      send(8'h00, 1);
      wait_outcome(n + 1);
      wait_dev(dev_frames + 1);
      dev_ack = 1'b1;

      // Device stops after edge 4; a mid-frame request must be ignored.
      n = outcomes;
      dev_stop_after = 4;
      begin
         int f;
         f = dev_frames;
         d = 8'($urandom_range(0, 255));
         send(d, 2);
         wait_dev(f + 1);
      end
      @(negedge clk);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      check("busy_ready_low", tx_ready, 0);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_outcome(n + 1);
      dev_stop_after = 11;

      // Reset during SHIFT after edge 6: lines release without a clock edge.
      n = outcomes;
      dev_stop_after = 6;
      begin
         int f;
         f = dev_frames;
         send(8'hA5, 0);
         wait_dev(f + 1);
      end
      @(negedge clk);
      check("midframe_still_busy", rx_inhibit, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_clk_oe", ps2clk_oe, 0);
      check("async_reset_dat_oe", ps2dat_oe, 0);
      exp_q.delete();
      dev_stop_after = 11;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("no_pulse_on_abort", outcomes, n);

      // Fresh transfer after reset.
      send(8'hF4, 0);
      wait_outcome(n + 1);

      repeat (20) @(negedge clk);
      check("frames_started", starts, frames_sent);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
